ysyx22040413_mc_core: RTL and testbench
=======================================

Name: ysyx22040413_mc_core

Overview:
- Parametrised multi-cycle RV core; successor to the single-cycle top.
- Replaces the combinational instruction input with a valid/ready fetch request and a variable-latency response.
- Internal fetch/wait/execute FSM, internal register file, commit trace port for the difftest bench.
- Supports ADDI, ADD, LUI, AUIPC, JAL, JALR and EBREAK (halt); anything else traps.

Parameters:
- XLEN, 64, datapath/PC width (32 or 64).
- NREG, 32, architectural registers (32 = RV-I, 16 = RV-E).
- RESET_PC, 'h80000000, PC value after reset (zero-extended to XLEN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (= pc).
- imem_rsp_valid  in  1  instruction word valid.
- imem_rsp_data  in  32  instruction word.
- pc  out  XLEN  current PC.
- commit_valid  out  1  one-cycle pulse per retired instruction.
- commit_pc  out  XLEN  PC of retired instruction.
- commit_wen  out  1  retired instruction wrote a register (rd!=0).
- commit_rd  out  5  destination index.
- commit_wdata  out  XLEN  value written.
- halt  out  1  sticky: EBREAK retired or trap taken.
- trap  out  1  sticky: halt was caused by an illegal condition.

Behaviour:
- Reset (rst=0, async): FSM=FETCH, pc=RESET_PC, all regs=0, all other outputs 0. Takes effect immediately, including mid-fetch.
- FETCH state:
  - imem_req_valid=1, imem_req_addr=pc; both held stable until imem_req_ready=1.
  - On handshake, go to WAIT.
- WAIT state:
  - imem_req_valid=0.
  - On imem_rsp_valid=1, latch imem_rsp_data into the IR and go to EXEC.
  - imem_rsp_valid is ignored in every other state (covers stale responses after reset).
- EXEC state (single cycle):
  - Decode the IR, read rs1/rs2, compute, write rd, update pc, pulse commit_valid, return to FETCH.
- Minimum latency: 3 cycles per instruction (ready=1, response the cycle after acceptance).
- Arithmetic:
  - ADD/ADDI wrap modulo 2^XLEN; immediates are sign-extended to XLEN.
  - LUI: rd = sext(imm[31:12]<<12).
  - AUIPC: rd = pc + sext(imm[31:12]<<12).
  - JAL: rd = pc+4, pc = pc + sext(J-imm).
  - JALR: t = (rs1 + sext(I-imm)) & ~1; rd = pc+4; pc = t. rs1 is read before the rd write, so rd==rs1 is legal.
  - All other instructions: pc = pc+4.
- x0: reads 0; writes discarded; commit_wen=0 when rd=0.
- Trap conditions (checked in EXEC), in priority order:
  - unsupported opcode/funct;
  - any register index >= NREG;
  - branch target bit1 set.
  - Effect: no architectural update, commit_valid=0, halt=1, trap=1, FSM enters HALT.
- EBREAK (0x00100073): commit_valid=1 with commit_wen=0, halt=1, trap=0, FSM enters HALT.
- HALT state: absorbing until reset. imem_req_valid=0, pc frozen, commit_valid=0.
- commit_* fields are valid only while commit_valid=1; otherwise they hold their last value.

Test Plan:
- Reset then ready=1, response 1 cycle later, ADDI x1,x0,5 (0x00500093) -> first imem_req_addr=0x80000000; commit_valid on the 3rd cycle with rd=1, wdata=5; next request addr=0x80000004.
- ADD x2,x1,x1 (0x00108133) after x1=5 with imem_req_ready held low for 4 cycles -> req_valid/addr stable throughout; commit wdata=10. With x1=0xFFFF_FFFF_FFFF_FFFF -> wdata=0xFFFF_FFFF_FFFF_FFFE (wrap).
- JAL x1,+8 (0x008000EF) at 0x80000000 -> wdata=0x80000004, next addr=0x80000008. Then JALR x0,0(x1) (0x00008067) -> commit_wen=0, next addr=0x80000004.
- LUI x3,0x12345 (0x123451B7) with XLEN=64 -> wdata=0x12345000. Repeat with imm 0x80000 -> wdata=0xFFFF_FFFF_8000_0000.
- 0xFFFFFFFF, and, with NREG=16, ADDI x17,x0,1 -> no commit, halt=1, trap=1, no further requests. EBREAK -> commit_valid=1, halt=1, trap=0.
- Drop rst while in WAIT, then pulse imem_rsp_valid after release -> pulse ignored; fresh request to 0x80000000; all regs read 0.

Source files
------------

// File: rtl/ysyx22040413_mc_core.sv
// Multi-cycle RV core: fetch/wait/exec FSM with a valid/ready fetch port,
// internal register file and a commit trace port.
module ysyx22040413_mc_core #(
    parameter int          XLEN     = 64,
    parameter int          NREG     = 32,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [XLEN-1:0] pc,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic            commit_wen,
    output logic [4:0]      commit_rd,
    output logic [XLEN-1:0] commit_wdata,
    output logic            halt,
    output logic            trap
);

    localparam int IW = $clog2(NREG);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] rf [NREG];
    logic            halt_q, trap_q;

    logic [XLEN-1:0] last_pc_q;
    logic            last_wen_q;
    logic [4:0]      last_rd_q;
    logic [XLEN-1:0] last_wdata_q;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];

    logic [XLEN-1:0] i_imm, u_imm, j_imm;

    assign i_imm = XLEN'($signed(ir_q[31:20]));
    assign u_imm = XLEN'($signed({ir_q[31:12], 12'h000}));
    assign j_imm = XLEN'($signed({ir_q[31], ir_q[19:12], ir_q[20],
                                  ir_q[30:21], 1'b0}));

    logic is_addi, is_add, is_lui, is_auipc;
    logic is_jal, is_jalr, is_ebreak;

    assign is_addi   = (opcode == 7'b0010011) && (f3 == 3'b000);
    assign is_add    = (opcode == 7'b0110011) && (f3 == 3'b000)
                       && (f7 == 7'b0000000);
    assign is_lui    = (opcode == 7'b0110111);
    assign is_auipc  = (opcode == 7'b0010111);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111) && (f3 == 3'b000);
    assign is_ebreak = (ir_q == 32'h0010_0073);

    logic uses_rs1, uses_rs2, uses_rd;

    assign uses_rs1 = is_addi | is_add | is_jalr;
    assign uses_rs2 = is_add;
    assign uses_rd  = is_addi | is_add | is_lui | is_auipc
                      | is_jal | is_jalr;

    function automatic logic bad_idx(input logic [4:0] r);
        return {1'b0, r} >= 6'(NREG);
    endfunction

    logic [XLEN-1:0] rv1, rv2;

    assign rv1 = rf[rs1[IW-1:0]];
    assign rv2 = rf[rs2[IW-1:0]];

    logic [XLEN-1:0] alu, next_pc, pc4;
    logic            jump, illegal;

    assign pc4 = pc_q + XLEN'(4);

    always_comb begin
        alu     = '0;
        next_pc = pc4;
        jump    = 1'b0;
        illegal = 1'b0;
        unique case (1'b1)
            is_addi:   alu = rv1 + i_imm;
            is_add:    alu = rv1 + rv2;
            is_lui:    alu = u_imm;
            is_auipc:  alu = pc_q + u_imm;
            is_jal: begin
                alu     = pc4;
                next_pc = pc_q + j_imm;
                jump    = 1'b1;
            end
            is_jalr: begin
                alu     = pc4;
                next_pc = (rv1 + i_imm) & ~XLEN'(1);
                jump    = 1'b1;
            end
            is_ebreak: alu = '0;
            default:   illegal = 1'b1;
        endcase
    end

    logic reg_bad, trap_now, exec_ok, wen_now;

    assign reg_bad = (uses_rs1 && bad_idx(rs1))
                   | (uses_rs2 && bad_idx(rs2))
                   | (uses_rd  && bad_idx(rd));
    // No compressed support, so any jump target with bit1 set is misaligned
    assign trap_now = illegal | reg_bad | (jump & next_pc[1]);
    assign exec_ok  = (state_q == S_EXEC) && !trap_now;
    assign wen_now  = uses_rd && (rd != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (trap_now || is_ebreak) state_d = S_HALT;
                else                       state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC[XLEN-1:0];
            ir_q         <= '0;
            halt_q       <= 1'b0;
            trap_q       <= 1'b0;
            last_pc_q    <= '0;
            last_wen_q   <= 1'b0;
            last_rd_q    <= '0;
            last_wdata_q <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (state_q == S_WAIT && imem_rsp_valid) ir_q <= imem_rsp_data;
            if (state_q == S_EXEC) begin
                if (trap_now) begin
                    halt_q <= 1'b1;
                    trap_q <= 1'b1;
                end else begin
                    pc_q         <= next_pc;
                    last_pc_q    <= pc_q;
                    last_wen_q   <= wen_now;
                    last_rd_q    <= rd;
                    last_wdata_q <= alu;
                    if (wen_now) rf[rd[IW-1:0]] <= alu;
                    if (is_ebreak) halt_q <= 1'b1;
                end
            end
        end
    end

    // Trace fields show the retiring instruction live, then hold it
    assign commit_valid = exec_ok;
    assign commit_pc    = exec_ok ? pc_q    : last_pc_q;
    assign commit_wen   = exec_ok ? wen_now : last_wen_q;
    assign commit_rd    = exec_ok ? rd      : last_rd_q;
    assign commit_wdata = exec_ok ? alu     : last_wdata_q;

    assign imem_req_addr = pc_q;
    assign pc            = pc_q;
    assign halt          = halt_q;
    assign trap          = trap_q;

endmodule

// File: tb/tb_ysyx22040413_mc_core.sv
// Bench for ysyx22040413_mc_core: directed steps plus random programs
// checked against an instruction-level reference model.
module tb_ysyx22040413_mc_core;

    localparam int          XLEN = 64;
    localparam int          NREG = 16;
    localparam logic [63:0] RPC  = 64'h8000_0000;

    logic            clk;
    logic            rst;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic [XLEN-1:0] pc;
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic            commit_wen;
    logic [4:0]      commit_rd;
    logic [XLEN-1:0] commit_wdata;
    logic            halt;
    logic            trap;

    ysyx22040413_mc_core #(
        .XLEN(XLEN),
        .NREG(NREG),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .pc(pc),
        .commit_valid(commit_valid),
        .commit_pc(commit_pc),
        .commit_wen(commit_wen),
        .commit_rd(commit_rd),
        .commit_wdata(commit_wdata),
        .halt(halt),
        .trap(trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] m_x [32];
    logic [63:0] m_pc;
    logic        m_halt;
    logic        m_trap;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_x[k] = 64'd0;
        m_pc   = RPC;
        m_halt = 1'b0;
        m_trap = 1'b0;
    endtask

    // Architectural effect of one instruction on the model state
    task automatic model_exec(input logic [31:0] i, output logic cv,
                              output logic wen, output logic [4:0] rdo,
                              output logic [63:0] wd);
        logic [63:0] a, b, imm_i, imm_u, imm_j, res, npc;
        logic [20:0] jj;
        logic        legal, ur1, ur2, urd, jmp, ebrk, bad_c;
        a     = m_x[i[19:15]];
        b     = m_x[i[24:20]];
        imm_i = 64'($signed(i[31:20]));
        imm_u = 64'($signed({i[31:12], 12'h000}));
        jj    = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        imm_j = 64'($signed(jj));
        npc   = m_pc + 64'd4;
        res   = 64'd0;
        legal = 1'b1;
        ur1   = 1'b0;
        ur2   = 1'b0;
        urd   = 1'b1;
        jmp   = 1'b0;
        ebrk  = 1'b0;
        if (i == 32'h0010_0073) begin
            ebrk = 1'b1;
            urd  = 1'b0;
        end else begin
            case (i[6:0])
                7'h13: begin
                    legal = (i[14:12] == 3'd0);
                    ur1   = 1'b1;
                    res   = a + imm_i;
                end
                7'h33: begin
                    legal = (i[14:12] == 3'd0) && (i[31:25] == 7'd0);
                    ur1   = 1'b1;
                    ur2   = 1'b1;
                    res   = a + b;
                end
                7'h37: res = imm_u;
                7'h17: res = m_pc + imm_u;
                7'h6F: begin
                    res = m_pc + 64'd4;
                    npc = m_pc + imm_j;
                    jmp = 1'b1;
                end
                7'h67: begin
                    legal = (i[14:12] == 3'd0);
                    ur1   = 1'b1;
                    res   = m_pc + 64'd4;
                    npc   = (a + imm_i) & ~64'd1;
                    jmp   = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end
        bad_c = !legal
              || (ur1 && int'(i[19:15]) >= NREG)
              || (ur2 && int'(i[24:20]) >= NREG)
              || (urd && int'(i[11:7]) >= NREG)
              || (jmp && npc[1]);
        rdo = i[11:7];
        wd  = res;
        if (bad_c) begin
            cv     = 1'b0;
            wen    = 1'b0;
            m_halt = 1'b1;
            m_trap = 1'b1;
        end else begin
            cv  = 1'b1;
            wen = urd && (i[11:7] != 5'd0);
            if (wen) m_x[i[11:7]] = res;
            m_pc = npc;
            if (ebrk) m_halt = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("rst_pc", pc, RPC);
        chk1("rst_commit_valid", commit_valid, 1'b0);
        chk1("rst_commit_wen", commit_wen, 1'b0);
        chk("rst_commit_wdata", commit_wdata, 64'd0);
        chk1("rst_halt", halt, 1'b0);
        chk1("rst_trap", trap, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One fetch/response/execute round trip with configurable stalls
    task automatic exec_one(input logic [31:0] insn, input int rdly,
                            input int sdly);
        logic        cv, wen;
        logic [4:0]  rdo;
        logic [63:0] wd, opc;
        chk1("req_valid", imem_req_valid, 1'b1);
        chk("req_addr", imem_req_addr, m_pc);
        chk("pc", pc, m_pc);
        for (int k = 0; k < rdly; k++) begin
            imem_req_ready = 1'b0;
            @(negedge clk);
            chk1("req_hold_valid", imem_req_valid, 1'b1);
            chk("req_hold_addr", imem_req_addr, m_pc);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk1("wait_req_valid", imem_req_valid, 1'b0);
        for (int k = 0; k < sdly; k++) begin
            imem_rsp_data = $urandom;
            @(negedge clk);
            chk1("wait_no_commit", commit_valid, 1'b0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = insn;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        opc = m_pc;
        model_exec(insn, cv, wen, rdo, wd);
        chk1("commit_valid", commit_valid, cv);
        if (cv) begin
            chk("commit_pc", commit_pc, opc);
            chk1("commit_wen", commit_wen, wen);
            if (wen) begin
                chk("commit_rd", 64'(commit_rd), 64'(rdo));
                chk("commit_wdata", commit_wdata, wd);
            end
        end
        @(negedge clk);
        chk1("commit_pulse", commit_valid, 1'b0);
        if (cv && wen) chk("commit_hold", commit_wdata, wd);
        chk1("halt", halt, m_halt);
        chk1("trap", trap, m_trap);
        chk("pc_after", pc, m_pc);
        chk1("req_after", imem_req_valid, !m_halt);
    endtask

    task automatic halt_idle();
        for (int k = 0; k < 4; k++) begin
            imem_req_ready = 1'b1;
            @(negedge clk);
            chk1("halt_no_req", imem_req_valid, 1'b0);
            chk1("halt_no_commit", commit_valid, 1'b0);
            chk("halt_pc", pc, m_pc);
        end
        imem_req_ready = 1'b0;
    endtask

    // ADD xk,xk,x0 exposes every register through commit_wdata
    task automatic readback();
        for (int k = 1; k < NREG; k++) begin
            logic [4:0] r;
            r = 5'(k);
            exec_one({7'd0, 5'd0, r, 3'd0, r, 7'h33}, 0, 0);
        end
    endtask

    function automatic logic [31:0] rnd_insn();
        logic [4:0]  rd, r1, r2;
        logic [11:0] im;
        logic [31:0] u;
        logic [20:0] off;
        int          sel, o;
        rd  = 5'($urandom_range(0, NREG - 1));
        r1  = 5'($urandom_range(0, NREG - 1));
        r2  = 5'($urandom_range(0, NREG - 1));
        u   = $urandom;
        im  = u[11:0];
        sel = $urandom_range(0, 19);
        if (sel == 18 && $urandom_range(0, 3) == 0)
            return 32'h0010_0073;
        if (sel == 19 && $urandom_range(0, 3) == 0)
            return u;
        if (sel <= 6 || sel == 18)
            return {im, r1, 3'd0, rd, 7'h13};
        if (sel <= 10 || sel == 19)
            return {7'd0, r2, r1, 3'd0, rd, 7'h33};
        if (sel <= 12)
            return {u[31:12], rd, 7'h37};
        if (sel <= 14)
            return {u[31:12], rd, 7'h17};
        if (sel <= 16) begin
            o = (int'($urandom_range(0, 511)) - 256) * 4;
            if ($urandom_range(0, 7) == 0) o = o + 2;
            off = o[20:0];
            return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
        end
        return {im[11:2], 2'b00, r1, 3'd0, rd, 7'h67};
    endfunction

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        model_reset();
        do_reset();

        exec_one(32'h0050_0093, 0, 0);
        exec_one(32'h0010_8133, 4, 0);
        exec_one(32'hFFF0_0093, 0, 1);
        exec_one(32'h0010_8133, 0, 0);

        do_reset();
        exec_one(32'h0080_00EF, 0, 0);
        exec_one(32'h0000_8067, 1, 2);
        exec_one(32'h1234_51B7, 0, 0);
        exec_one(32'h8000_01B7, 0, 0);
        exec_one(32'h0010_0073, 0, 0);
        halt_idle();

        do_reset();
        exec_one(32'hFFFF_FFFF, 0, 0);
        halt_idle();
        do_reset();
        exec_one(32'h0010_0893, 0, 0);
        halt_idle();
        do_reset();
        exec_one(32'h0020_00EF, 0, 0);
        halt_idle();

        do_reset();
        for (int n = 0; n < 120; n++) begin
            exec_one(rnd_insn(), $urandom_range(0, 2), $urandom_range(0, 2));
            if (m_halt) begin
                halt_idle();
                do_reset();
            end
        end
        readback();

        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk1("midwait_in_wait", imem_req_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk1("midwait_async_req", imem_req_valid, 1'b1);
        chk("midwait_async_pc", pc, RPC);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0093;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk1("stale_rsp_no_commit", commit_valid, 1'b0);
        chk1("stale_rsp_req_valid", imem_req_valid, 1'b1);
        chk("stale_rsp_req_addr", imem_req_addr, RPC);
        @(negedge clk);
        chk1("stale_rsp_still_idle", commit_valid, 1'b0);
        readback();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
